line_memory_responder: RTL and testbench

LINE_MEMORY_RESPONDER -- requirements
Module: line_memory_responder

---
 rtl/line_memory_responder.sv | 125 ++++++++++++
 tb/tb_line_memory_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/line_memory_responder.sv
// Fixed-latency 256-bit line memory answering a cache initiator.
// Define LINE_MEM_ALIGN_CHECK_EN to add the sticky misaligned-address flag on err_o.
module line_memory_responder #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic [255:0] data_o,
    output logic         ack_o,
    output logic         busy_o,
    output logic         err_o
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [7:0]     cnt;
    logic [7:0]     cnt_n;
    logic           accept;
    logic           done;

    logic [IW-1:0]  idx_q;
    logic           wr_q;
    logic [255:0]   data_q;

    logic [255:0]   mem [DEPTH];

    logic           unused;
    assign unused = ^addr_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // ACK falls through to IDLE; a request already waiting on that edge is
    // taken at once so back-to-back requests are LATENCY+1 cycles apart.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        done    = 1'b0;
        unique case (state)
            S_IDLE, S_ACK: begin
                state_n = S_IDLE;
                if (enable_i) begin
                    accept  = 1'b1;
                    cnt_n   = 8'(LATENCY - 1);
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 8'd0) begin
                    done    = 1'b1;
                    state_n = S_ACK;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            wr_q   <= 1'b0;
            data_q <= '0;
            data_o <= '0;
        end else begin
            if (accept) begin
                idx_q  <= addr_i[5+IW-1:5];
                wr_q   <= write_i;
                data_q <= data_i;
            end
            if (done && !wr_q) begin
                data_o <= mem[idx_q];
            end
        end
    end

    // Storage has no reset; only a reset on the committing edge blocks a write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && done && wr_q) begin
            mem[idx_q] <= data_q;
        end
    end

    assign ack_o  = (state == S_ACK);
    assign busy_o = (state != S_IDLE);

`ifdef LINE_MEM_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (accept && (addr_i[4:0] != 5'd0)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_line_memory_responder.sv
// Randomized bench for line_memory_responder against a line-array model.
// Honours LINE_MEM_ALIGN_CHECK_EN when predicting err_o.
module tb_line_memory_responder;

    localparam int LAT   = 10;
    localparam int DEPTH = 512;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] wdata = '0;
    logic [255:0] rdata;
    logic         ack;
    logic         busy;
    logic         err;

    int nvec = 0;
    int nerr = 0;

    logic [255:0] mdl [DEPTH];
    logic [31:0]  written [$];
    logic [255:0] last_rd = '0;
    logic         err_exp = 1'b0;

    always #5 clk = ~clk;

    line_memory_responder #(
        .LATENCY(LAT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .enable_i(enable),
        .write_i (write),
        .addr_i  (addr),
        .data_i  (wdata),
        .data_o  (rdata),
        .ack_o   (ack),
        .busy_o  (busy),
        .err_o   (err)
    );

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32) % DEPTH);
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_outs(input logic ack_e, input logic busy_e);
        check("ack", 256'(ack), 256'(ack_e));
        check("busy", 256'(busy), 256'(busy_e));
        check("data_o", rdata, last_rd);
        check("err", 256'(err), 256'(err_exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        last_rd = '0;
        err_exp = 1'b0;
        check_outs(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable = 1'b0;
            @(posedge clk);
            #1;
            check_outs(1'b0, 1'b0);
        end
    endtask

    // mode 0: hold inputs, 1: scramble from cycle 2, 2: drop enable and move addr to 0x80
    task automatic req(input bit wr, input logic [31:0] a,
                       input logic [255:0] d, input int mode, input int rst_at);
        int ln;
        ln = line_of(a);
        @(negedge clk);
        enable = 1'b1;
        write = wr;
        addr = a;
        wdata = d;
        @(posedge clk);
`ifdef LINE_MEM_ALIGN_CHECK_EN
        if (a % 32 != 0) err_exp = 1'b1;
`endif
        #1;
        check_outs(1'b0, 1'b1);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k >= 2 && mode == 1) begin
                enable = 1'($urandom);
                write = 1'($urandom);
                addr = $urandom;
                wdata = rnd256();
            end else if (k >= 2 && mode == 2) begin
                enable = 1'b0;
                addr = 32'h80;
            end
            if (k == rst_at) rst = 1'b1;
            @(posedge clk);
            #1;
            if (k == rst_at) begin
                last_rd = '0;
                err_exp = 1'b0;
                check_outs(1'b0, 1'b0);
                @(negedge clk);
                rst = 1'b0;
                enable = 1'b0;
                return;
            end
            if (k == LAT) begin
                if (wr) begin
                    mdl[ln] = d;
                    written.push_back(a);
                end else begin
                    last_rd = mdl[ln];
                end
            end
            check_outs(k == LAT, 1'b1);
        end
    endtask

    initial begin
        logic [255:0] pa;
        logic [255:0] pb;
        logic [255:0] pc;
        pa = {16{16'hA5A5}};
        pb = rnd256();
        pc = rnd256();

        do_reset();
        idle(2);

        req(1'b1, 32'h40, pa, 0, 0);
        req(1'b0, 32'h40, '0, 0, 0);
        check("rd_pattern", rdata, pa);
        idle(1);

        req(1'b1, 32'h80, pc, 0, 0);
        req(1'b0, 32'h40, '0, 2, 0);
        check("rd_ignore_wait", rdata, pa);
        idle(2);

        req(1'b1, 32'h4040, pb, 0, 0);
        req(1'b0, 32'h0040, '0, 0, 0);
        check("rd_alias", rdata, pb);

        req(1'b1, 32'h40, rnd256(), 0, 5);
        idle(1);
        req(1'b0, 32'h40, '0, 0, 0);
        check("rd_after_abort", rdata, pb);

        req(1'b0, 32'h44, '0, 0, 0);
        check("rd_misaligned", rdata, pb);
        idle(3);
        do_reset();
        idle(1);

        for (int t = 0; t < 60; t++) begin
            bit wr;
            logic [31:0] a;
            wr = (written.size() == 0) || ($urandom_range(0, 2) == 0);
            if (wr) begin
                a = $urandom;
                if ($urandom_range(0, 1) == 0) a[4:0] = 5'd0;
            end else begin
                a = written[$urandom_range(0, written.size() - 1)];
                a[31:14] = 18'($urandom);
                a[4:0] = 5'($urandom_range(0, 3) == 0 ? $urandom : 0);
            end
            req(wr, a, rnd256(), $urandom_range(0, 1),
                ($urandom_range(0, 9) == 0) ? $urandom_range(1, LAT) : 0);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) do_reset();
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
